// File: rtl/simple_pkg.sv
// Shared phase and state definitions for the SIMPLE multi-cycle control path.
// No logic; constants only.
package simple_pkg;

  localparam int PH_N   = 5;
  localparam int PH_IF  = 0;
  localparam int PH_RD  = 1;
  localparam int PH_EX  = 2;
  localparam int PH_MEM = 3;
  localparam int PH_WB  = 4;

  localparam logic [PH_N-1:0] PH_FIRST = 5'b00001;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

endpackage

// File: rtl/phase_ring.sv
// One-hot phase rotator: load_first/clear take effect on the next edge, rotation one step per clock.
// hold freezes the current phase so a stalled enable stays asserted.
module phase_ring
  import simple_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            load_first,
  input  logic            hold,
  input  logic            clear,
  output logic [PH_N-1:0] ph
);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      ph <= '0;
    end else if (load_first) begin
      ph <= PH_FIRST;
    end else if (!hold) begin
      ph <= {ph[PH_N-2:0], ph[PH_N-1]};
    end
  end

endmodule

// File: rtl/phase_sequencer.sv
// Run/pause/halt control around the phase ring; all outputs registered, one clock from input to effect.
// mem_wait stretches P1/P4 in place; stop requests are deferred to the next end of P5.
module phase_sequencer
  import simple_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             exec_pulse,
  input  logic             step_mode,
  input  logic             halt_req,
  input  logic             mem_wait,
  output logic [PH_N-1:0]  ph,
  output logic             running,
  output logic             halted,
  output logic             stall,
  output logic [CNT_W-1:0] instr_cnt,
  output logic [CNT_W-1:0] cycle_cnt
);

  state_t state;
  logic   pause_pend;

  logic in_run;
  logic mem_hold;
  logic wb_end;
  logic stop_now;
  logic ring_load;
  logic ring_clear;

  assign in_run   = (state == ST_RUN);
  assign mem_hold = in_run && mem_wait && (ph[PH_IF] || ph[PH_MEM]);
  assign wb_end   = in_run && ph[PH_WB];
  // A pulse landing on the P5 cycle counts as a pause for this very boundary.
  assign stop_now   = halt_req || pause_pend || exec_pulse || step_mode;
  assign ring_load  = !in_run && exec_pulse;
  assign ring_clear = wb_end && stop_now;

  phase_ring u_ring (
    .clk        (clk),
    .rst        (rst),
    .load_first (ring_load),
    .hold       (mem_hold),
    .clear      (ring_clear),
    .ph         (ph)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      pause_pend <= 1'b0;
      running    <= 1'b0;
      halted     <= 1'b0;
      stall      <= 1'b0;
      instr_cnt  <= '0;
      cycle_cnt  <= '0;
    end else begin
      stall <= mem_hold;
      if (in_run) begin
        cycle_cnt <= cycle_cnt + CNT_W'(1);
      end
      case (state)
        ST_IDLE, ST_HALT: begin
          if (exec_pulse) begin
            state   <= ST_RUN;
            running <= 1'b1;
            halted  <= 1'b0;
          end
        end
        ST_RUN: begin
          if (exec_pulse) begin
            pause_pend <= 1'b1;
          end
          if (wb_end) begin
            instr_cnt <= instr_cnt + CNT_W'(1);
            if (halt_req) begin
              state      <= ST_HALT;
              running    <= 1'b0;
              halted     <= 1'b1;
              pause_pend <= 1'b0;
            end else if (pause_pend || exec_pulse || step_mode) begin
              state      <= ST_IDLE;
              running    <= 1'b0;
              pause_pend <= 1'b0;
            end
          end
        end
        default: begin
          state   <= ST_IDLE;
          running <= 1'b0;
          halted  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/phase_sequencer.md
# phase_sequencer

Multi-cycle control sequencer for the SIMPLE processor datapath. It replaces the free-running phase counter with a state machine that emits one-hot phase enables. IF, register read, execute, memory and write-back/PC update each get one phase. Phases advance only while the machine is running, stretch under memory wait, and stop cleanly at instruction boundaries on halt, pause or single-step. It sits between the debounced exec button, the instruction decoder's halt output, and every phase-enabled register in the datapath.

## Interface
- CNT_W, 16, width of instruction and cycle counters
- clk  in  1  system clock; sole clock
- rst  in  1  reset, synchronous, active-high
- exec_pulse  in  1  one-cycle pulse from the chattering remover: start, resume or pause
- step_mode  in  1  1 = stop after each instruction
- halt_req  in  1  decoder HLT indication, valid during P5
- mem_wait  in  1  memory not ready; stalls P1 and P4 only
- ph  out  5  one-hot phase enables: ph[0]=P1 fetch, ph[1]=P2 read, ph[2]=P3 exec, ph[3]=P4 mem, ph[4]=P5 write-back/PC
- running  out  1  state is RUN
- halted  out  1  state is HALT
- stall  out  1  current phase held by mem_wait
- instr_cnt  out  CNT_W  completed instructions
- cycle_cnt  out  CNT_W  clocks spent in RUN, including stalls

## Operation
- States: IDLE, RUN, HALT. An internal pause_pend flag is also kept.
- Reset values: state=IDLE, ph=0, running=0, halted=0, stall=0, pause_pend=0, both counters 0.
- IDLE: ph=0. exec_pulse moves the machine to RUN with ph=00001.
- RUN, normal advance: ph rotates P1→P2→P3→P4→P5, one phase per clock.
- RUN, stall: when mem_wait=1 and ph[0] or ph[3] is high, ph holds its value and stall=1. The enable stays asserted, and the datapath captures on the last cycle. mem_wait is ignored in P2, P3 and P5.
- RUN, exec_pulse: sets pause_pend. Pulses that arrive while pause_pend is already 1 are ignored.
- End of P5 (the cycle in which ph[4]=1); instr_cnt increments (wraps) and the next state is chosen by priority:
  - halt_req=1 → HALT, ph=0.
  - else pause_pend=1 or step_mode=1 → IDLE, ph=0.
  - else → P1.
  - pause_pend clears on leaving RUN.
- HALT: halted=1, ph=0. exec_pulse → RUN at P1 and clears halted.
- cycle_cnt increments on every clock with state=RUN and wraps at 2^CNT_W.
- step_mode may change at any time. It is sampled only at the end of P5.
- Reset mid-instruction: every register returns to its reset value on that edge. The partial instruction is abandoned and no counter increments.

## Timing
- All outputs are registered. ph changes only on clk edges.
- Start latency: exec_pulse high at edge N gives ph=00001 after edge N.
- Minimum instruction length: 5 clocks. Each mem_wait cycle in P1 or P4 adds 1 clock.
- Between instructions: P5 at cycle k is followed by P1 at k+1. There is no bubble.
- Stop latency: pause or halt takes effect at the first P5 end after the request. ph=0 on the next clock.
- exec_pulse arriving on the same cycle as the end of P5: it sets pause_pend and is also honoured at that same boundary, so the machine goes to IDLE.
- halt_req together with a pending pause: HALT wins.
- Exactly one bit of ph is high in RUN. All bits are 0 otherwise.

## Structure
- simple_pkg holds:
  - phase index constants PH_IF=0, PH_RD=1, PH_EX=2, PH_MEM=3, PH_WB=4;
  - the state encoding ST_IDLE, ST_RUN, ST_HALT;
  - the 5-bit one-hot constant PH_FIRST=5'b00001.
- One sub-module, phase_ring: a 5-bit one-hot rotator with load-first, hold and clear inputs.
- The FSM, pause_pend and both counters stay in phase_sequencer.

## Test plan
- Reset, then exec_pulse → ph sequence 00001, 00010, 00100, 01000, 10000, 00001. instr_cnt=1 at the second 00001. running=1.
- mem_wait=1 for 3 clocks during P1 and 2 clocks during P4 → that instruction takes 10 clocks. stall=1 exactly 5 clocks. cycle_cnt=10. mem_wait during P3 has no effect.
- step_mode=1, then exec_pulse three times, each after the previous stop → exactly 3 instructions, ph=0 between them, instr_cnt=3, cycle_cnt=15.
- halt_req=1 in P5 of the 2nd instruction → halted=1, ph=0, instr_cnt=2. A later exec_pulse restarts at P1 with halted=0.
- exec_pulse during P2 of a running instruction → instruction completes, machine enters IDLE after P5. A second pulse during P4 is ignored. halt_req together with a pending pause → HALT.
- rst asserted during P3 → next clock ph=0, counters 0, state IDLE. exec_pulse restarts at P1.
